// File: rtl/sample_fifo_ring.sv
// sample_fifo_ring: single-clock sample FIFO with stop-on-full or circular
// overwrite capture, registered status flags and sticky event flags.
// Storage is a plain array with a synchronous, enabled read port so it maps
// onto block RAM; only the control state and the read register are reset.
module sample_fifo_ring #(
   parameter int DATA_WIDTH    = 8,
   parameter int DEPTH         = 32768,
   parameter int AFULL_THRESH  = DEPTH - 4,
   parameter int AEMPTY_THRESH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    ring_mode,
   input  logic                    wr_en,
   input  logic [DATA_WIDTH-1:0]   data_in,
   input  logic                    rd_en,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic                    rd_valid,
   output logic                    full,
   output logic                    empty,
   output logic                    almost_full,
   output logic                    almost_empty,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow,
   output logic                    underflow,
   output logic                    wrapped
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
   localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  full_q, full_d;
   logic                  empty_q, empty_d;
   logic                  afull_q, afull_d;
   logic                  aempty_q, aempty_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic                  wrap_q, wrap_d;
   logic                  rd_valid_q, rd_valid_d;
   logic [DATA_WIDTH-1:0] data_out_q;

   logic                  rd_acc;
   logic                  wr_acc;
   logic                  overwrite;

   // Accept decisions; clear suppresses both ports for the cycle.
   always_comb begin
      rd_acc    = rd_en && !empty_q && !clear;
      wr_acc    = wr_en && (!full_q || ring_mode || rd_acc) && !clear;
      // A ring-mode write into a full FIFO with no read displaces the oldest word.
      overwrite = wr_acc && full_q && !rd_acc;
   end

   // Next-state for pointers, occupancy, status and sticky flags.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      ovf_d      = ovf_q;
      udf_d      = udf_q;
      wrap_d     = wrap_q;
      rd_valid_d = 1'b0;

      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
         wrap_d   = 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (rd_acc || overwrite) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         rd_valid_d = rd_acc;

         // Occupancy moves only on an unpaired read or an unpaired, non-overwriting write.
         case ({wr_acc && !overwrite, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase

         if (wr_en && full_q && !ring_mode && !rd_acc) begin
            ovf_d = 1'b1;
         end
         if (rd_en && empty_q) begin
            udf_d = 1'b1;
         end
         if (overwrite) begin
            wrap_d = 1'b1;
         end
      end

      full_d   = (count_d == DEPTH_C);
      empty_d  = (count_d == '0);
      afull_d  = (count_d >= AFULL_C);
      aempty_d = (count_d <= AEMPTY_C);
   end

   // Control and flag registers, asynchronously reset to the empty state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         afull_q    <= 1'b0;
         aempty_q   <= 1'b1;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
         wrap_q     <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         afull_q    <= afull_d;
         aempty_q   <= aempty_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
         wrap_q     <= wrap_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // RAM write port; the array itself carries no reset.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr_q] <= data_in;
      end
   end

   // Synchronous RAM read into the output register; holds when no read is accepted.
   // A simultaneous write to the same address returns the old word (read-first).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out_q <= '0;
      end else if (rd_acc) begin
         data_out_q <= mem[rd_ptr_q];
      end
   end

   assign data_out     = data_out_q;
   assign rd_valid     = rd_valid_q;
   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = afull_q;
   assign almost_empty = aempty_q;
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;
   assign wrapped      = wrap_q;

endmodule

// File: tb/tb_sample_fifo_ring.sv
// Bench for sample_fifo_ring: directed scenarios plus a randomized run, all
// compared against a queue-based reference model after every clock edge.
module tb_sample_fifo_ring;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AF    = 12;
   localparam int AE    = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          clear;
   logic          ring_mode;
   logic          wr_en;
   logic [DW-1:0] data_in;
   logic          rd_en;
   logic [DW-1:0] data_out;
   logic          rd_valid;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic [4:0]    count;
   logic          overflow;
   logic          underflow;
   logic          wrapped;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [DW-1:0] mq[$];
   logic [DW-1:0] m_dout;
   logic          m_rv;
   logic          m_ovf;
   logic          m_udf;
   logic          m_wrap;

   sample_fifo_ring #(
      .DATA_WIDTH   (DW),
      .DEPTH        (DEPTH),
      .AFULL_THRESH (AF),
      .AEMPTY_THRESH(AE)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .ring_mode   (ring_mode),
      .wr_en       (wr_en),
      .data_in     (data_in),
      .rd_en       (rd_en),
      .data_out    (data_out),
      .rd_valid    (rd_valid),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .almost_empty(almost_empty),
      .count       (count),
      .overflow    (overflow),
      .underflow   (underflow),
      .wrapped     (wrapped)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ctx);
      int n;
      n = mq.size();
      chk({ctx, ".data_out"},     32'(data_out),     32'(m_dout));
      chk({ctx, ".rd_valid"},     32'(rd_valid),     32'(m_rv));
      chk({ctx, ".count"},        32'(count),        32'(n));
      chk({ctx, ".full"},         32'(full),         32'(n == DEPTH));
      chk({ctx, ".empty"},        32'(empty),        32'(n == 0));
      chk({ctx, ".almost_full"},  32'(almost_full),  32'(n >= AF));
      chk({ctx, ".almost_empty"}, 32'(almost_empty), 32'(n <= AE));
      chk({ctx, ".overflow"},     32'(overflow),     32'(m_ovf));
      chk({ctx, ".underflow"},    32'(underflow),    32'(m_udf));
      chk({ctx, ".wrapped"},      32'(wrapped),      32'(m_wrap));
   endtask

   task automatic model_reset();
      mq.delete();
      m_dout = '0;
      m_rv   = 1'b0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_wrap = 1'b0;
   endtask

   // Apply one clock of stimulus, advance the model, check 1 ns after the edge.
   task automatic step(input string ctx, input logic w, input logic [DW-1:0] d,
                       input logic r, input logic rm, input logic clr);
      bit is_full;
      bit rd_ok;
      bit wr_ok;
      wr_en     = w;
      data_in   = d;
      rd_en     = r;
      ring_mode = rm;
      clear     = clr;
      @(posedge clk);
      is_full = (mq.size() == DEPTH);
      rd_ok   = r && (mq.size() != 0);
      if (clr) begin
         mq.delete();
         m_rv   = 1'b0;
         m_ovf  = 1'b0;
         m_udf  = 1'b0;
         m_wrap = 1'b0;
      end else begin
         wr_ok = w && (!is_full || rm || rd_ok);
         if (r && mq.size() == 0) m_udf = 1'b1;
         if (w && is_full && !rm && !rd_ok) m_ovf = 1'b1;
         if (rd_ok) begin
            m_dout = mq.pop_front();
            m_rv   = 1'b1;
         end else begin
            m_rv = 1'b0;
         end
         if (wr_ok) begin
            if (is_full && !rd_ok) begin
               void'(mq.pop_front());
               m_wrap = 1'b1;
            end
            mq.push_back(d);
         end
      end
      #1;
      check_all(ctx);
      wr_en = 1'b0;
      rd_en = 1'b0;
      clear = 1'b0;
   endtask

   // Leave 9 words stored with overflow, underflow and wrapped all set.
   task automatic prep_sticky();
      step("prep.udf", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 17; i++) step("prep.wrap", 1'b1, 8'(8'h20 + i), 1'b0, 1'b1, 1'b0);
      step("prep.ovf", 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) step("prep.rd", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("prep.count9", 32'(count), 32'd9);
   endtask

   initial begin
      int wr_bias;
      reset     = 1'b1;
      clear     = 1'b0;
      ring_mode = 1'b0;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      data_in   = '0;
      model_reset();
      #3;
      check_all("reset_async");
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_all("reset_release");

      // Stop-on-full fill, dropped 17th write, ordered drain
      for (int i = 1; i <= 16; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      step("drop17", 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("drain.last", 32'(data_out), 32'h10);
      step("idle_hold", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // Circular overwrite: 20 writes keep the last 16
      step("clr1", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 20; i++) step("ring_fill", 1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
      step("ring_rd_first", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      chk("ring.first", 32'(data_out), 32'h05);
      for (int i = 0; i < 15; i++) step("ring_drain", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      chk("ring.last", 32'(data_out), 32'h14);

      // Full with simultaneous read and write in each mode
      for (int m = 0; m < 2; m++) begin
         step("clr2", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
         for (int i = 0; i < 16; i++) step("full_fill", 1'b1, 8'($urandom), 1'b0, 1'(m), 1'b0);
         step("full_rw", 1'b1, 8'h55, 1'b1, 1'(m), 1'b0);
         for (int i = 0; i < 16; i++) step("full_rw_drain", 1'b0, 8'h00, 1'b1, 1'(m), 1'b0);
         chk("full_rw.last55", 32'(data_out), 32'h55);
      end

      // Empty with simultaneous read and write: no bypass
      step("clr3", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      step("empty_rw", 1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
      step("empty_rw_rd", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("empty_rw.data", 32'(data_out), 32'h33);

      // Clear with 9 stored and sticky flags set
      step("clr4", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      prep_sticky();
      step("clear9", 1'b1, 8'h99, 1'b1, 1'b0, 1'b1);
      step("clr_wr7e", 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0);
      step("clr_rd7e", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("clear.7e", 32'(data_out), 32'h7E);

      // Asynchronous reset mid-operation with 9 stored and sticky flags set
      prep_sticky();
      wr_en   = 1'b1;
      rd_en   = 1'b1;
      data_in = 8'hC3;
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all("reset_mid");
      @(posedge clk);
      #1;
      check_all("reset_held");
      wr_en = 1'b0;
      rd_en = 1'b0;
      reset = 1'b0;
      step("rst_wr7e", 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0);
      step("rst_rd7e", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("reset.7e", 32'(data_out), 32'h7E);

      // Randomized phases biased toward filling and draining
      for (int ph = 0; ph < 8; ph++) begin
         wr_bias = (ph % 2 == 0) ? 85 : 20;
         for (int i = 0; i < 60; i++) begin
            step("rand",
                 1'($urandom_range(0, 99) < wr_bias),
                 8'($urandom),
                 1'($urandom_range(0, 99) >= wr_bias),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 99) == 0));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
